noc_packet_receiver: RTL and testbench

//  Local-port sink for the NoC packet format emitted by the test/traffic sender nodes.

---
 rtl/noc_packet_receiver_if.sv | 50 +++++
 rtl/noc_packet_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_noc_packet_receiver.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_packet_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_packet_receiver_if
//  Description : Router-side flit link and consumer-side payload stream of the
//                NoC packet receiver.
//  Revision    : 1.0
// ============================================================================
`ifndef NOC_PKT_FORMAT_DEFINES
`define NOC_PKT_FORMAT_DEFINES
`define Noc_Data_Width   32
`define Noc_ID_X_Width   4
`define Noc_ID_Y_Width   4
`define Noc_Point_H      28
`define Noc_Source_Point 27
`define Axi_Len_Point    12
`define Noc_Point_E      8
`define Noc_Head_H       4'hA
`define Noc_Head_E       4'h5
`define Noc_Tail_H       4'hC
`define Noc_Tail_E       4'h3
`endif

interface noc_packet_receiver_if;
    logic                       receive_valid;
    logic                       receive_ready;
    logic [`Noc_Data_Width-1:0] receive_flit;
    logic                       receive_is_header;
    logic                       receive_is_tail;
    logic                       payload_valid;
    logic                       payload_ready;
    logic [`Noc_Data_Width-1:0] payload_data;
    logic                       payload_last;

    // Receiver view: sinks flits, sources the payload stream.
    modport slave (
        input  receive_valid, receive_flit, receive_is_header, receive_is_tail,
        output receive_ready,
        output payload_valid, payload_data, payload_last,
        input  payload_ready
    );

    modport master (
        output receive_valid, receive_flit, receive_is_header, receive_is_tail,
        input  receive_ready,
        input  payload_valid, payload_data, payload_last,
        output payload_ready
    );
endinterface

`default_nettype wire

// File: rtl/noc_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : noc_packet_receiver
//  Description : Local-port packet sink: checks framing/destination, streams
//                payload with a last flag, reports packet status and errors.
//  Revision    : 1.0
// ============================================================================
`ifndef NOC_PKT_FORMAT_DEFINES
`define NOC_PKT_FORMAT_DEFINES
`define Noc_Data_Width   32
`define Noc_ID_X_Width   4
`define Noc_ID_Y_Width   4
`define Noc_Point_H      28
`define Noc_Source_Point 27
`define Axi_Len_Point    12
`define Noc_Point_E      8
`define Noc_Head_H       4'hA
`define Noc_Head_E       4'h5
`define Noc_Tail_H       4'hC
`define Noc_Tail_E       4'h3
`endif

module noc_packet_receiver #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID        = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID        = '0,
    parameter int unsigned                MAX_PAYLOAD = 16
) (
    input  wire logic                      noc_clk,
    input  wire logic                      noc_rst_n,
    noc_packet_receiver_if.slave           link,
    output logic                           pkt_done,
    output logic [`Noc_ID_X_Width-1:0]     pkt_src_x,
    output logic [`Noc_ID_Y_Width-1:0]     pkt_src_y,
    output logic [7:0]                     pkt_len,
    output logic                           err_valid,
    output logic [2:0]                     err_code,
    output logic [15:0]                    pkt_count,
    output logic [15:0]                    err_count
);

    localparam int          c_xw        = `Noc_ID_X_Width;
    localparam int          c_yw        = `Noc_ID_Y_Width;
    localparam int          c_sp        = `Noc_Source_Point;
    localparam logic [8:0]  c_cnt_limit = 9'(MAX_PAYLOAD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                     r_state;
    logic [8:0]                 r_cnt;
    logic                       r_hold_valid;
    logic [`Noc_Data_Width-1:0] r_hold_data;
    logic                       r_out_valid;
    logic [`Noc_Data_Width-1:0] r_out_data;
    logic                       r_out_last;
    logic [c_xw-1:0]            r_cur_x;
    logic [c_yw-1:0]            r_cur_y;

    logic [`Noc_Data_Width-1:0] w_flit;
    logic [3:0]                 w_mark_h;
    logic [3:0]                 w_mark_e;
    logic [c_xw-1:0]            w_src_x;
    logic [c_yw-1:0]            w_src_y;
    logic [c_xw-1:0]            w_dst_x;
    logic [c_yw-1:0]            w_dst_y;
    logic                       w_hdr_ok;
    logic                       w_tail_ok;
    logic                       w_accept;
    logic [8:0]                 w_cnt_inc;

    assign w_flit    = link.receive_flit;
    assign w_mark_h  = w_flit[`Noc_Data_Width-1:`Noc_Point_H];
    assign w_mark_e  = w_flit[`Axi_Len_Point-1:`Noc_Point_E];
    assign w_src_x   = w_flit[c_sp -: c_xw];
    assign w_src_y   = w_flit[c_sp-c_xw -: c_yw];
    assign w_dst_x   = w_flit[c_sp-c_xw-c_yw -: c_xw];
    assign w_dst_y   = w_flit[c_sp-2*c_xw-c_yw -: c_yw];
    // A flit flagged both header and tail never qualifies as a good header.
    assign w_hdr_ok  = link.receive_is_header && !link.receive_is_tail &&
                       (w_mark_h == `Noc_Head_H) && (w_mark_e == `Noc_Head_E) &&
                       (w_dst_x == X_ID) && (w_dst_y == Y_ID);
    assign w_tail_ok = (w_mark_h == `Noc_Tail_H) && (w_mark_e == `Noc_Tail_E);
    assign w_cnt_inc = r_cnt + 9'd1;

    // Hold register may only be refilled when its content can move to the output.
    assign link.receive_ready = !r_hold_valid || !r_out_valid || link.payload_ready;
    assign w_accept           = link.receive_valid && link.receive_ready;

    assign link.payload_valid = r_out_valid;
    assign link.payload_data  = r_out_data;
    assign link.payload_last  = r_out_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            pkt_done     <= 1'b0;
            pkt_src_x    <= '0;
            pkt_src_y    <= '0;
            pkt_len      <= '0;
            err_valid    <= 1'b0;
            err_code     <= '0;
            pkt_count    <= '0;
            err_count    <= '0;
        end else begin
            pkt_done  <= 1'b0;
            err_valid <= 1'b0;
            if (r_out_valid && link.payload_ready)
                r_out_valid <= 1'b0;

            if (w_accept) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (link.receive_is_header) begin
                            r_cnt   <= '0;
                            r_cur_x <= w_src_x;
                            r_cur_y <= w_src_y;
                            if (w_hdr_ok) begin
                                r_state <= S_PAYLOAD;
                            end else begin
                                r_state   <= S_DISCARD;
                                err_valid <= 1'b1;
                                err_code  <= 3'd2;
                                err_count <= sat_inc(err_count);
                            end
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= 3'd1;
                            err_count <= sat_inc(err_count);
                        end
                    end

                    S_PAYLOAD: begin
                        if (link.receive_is_header) begin
                            // Missing tail: flush held flit as last, then start over on this header.
                            if (r_hold_valid) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_hold_data;
                                r_out_last  <= 1'b1;
                            end
                            r_hold_valid <= 1'b0;
                            r_cnt        <= '0;
                            r_cur_x      <= w_src_x;
                            r_cur_y      <= w_src_y;
                            r_state      <= w_hdr_ok ? S_PAYLOAD : S_DISCARD;
                            err_valid    <= 1'b1;
                            err_code     <= 3'd3;
                            err_count    <= sat_inc(err_count);
                        end else if (link.receive_is_tail) begin
                            if (r_hold_valid) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_hold_data;
                                r_out_last  <= 1'b1;
                            end
                            r_hold_valid <= 1'b0;
                            r_state      <= S_IDLE;
                            pkt_done     <= 1'b1;
                            pkt_src_x    <= r_cur_x;
                            pkt_src_y    <= r_cur_y;
                            pkt_len      <= r_cnt[7:0];
                            pkt_count    <= sat_inc(pkt_count);
                            if (!w_tail_ok) begin
                                err_valid <= 1'b1;
                                err_code  <= 3'd5;
                                err_count <= sat_inc(err_count);
                            end
                        end else if (w_cnt_inc == c_cnt_limit) begin
                            r_hold_valid <= 1'b0;
                            r_state      <= S_DISCARD;
                            err_valid    <= 1'b1;
                            err_code     <= 3'd4;
                            err_count    <= sat_inc(err_count);
                        end else begin
                            if (r_hold_valid) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_hold_data;
                                r_out_last  <= 1'b0;
                            end
                            r_cnt        <= w_cnt_inc;
                            r_hold_valid <= 1'b1;
                            r_hold_data  <= w_flit;
                        end
                    end

                    S_DISCARD: begin
                        if (link.receive_is_tail && !link.receive_is_header)
                            r_state <= S_IDLE;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_packet_receiver
//  Description : Directed scoreboard bench for noc_packet_receiver.
//  Revision    : 1.0
// ============================================================================
module tb_noc_packet_receiver;

    logic        noc_clk   = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        pkt_done;
    logic [3:0]  pkt_src_x;
    logic [3:0]  pkt_src_y;
    logic [7:0]  pkt_len;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    always #5 noc_clk = ~noc_clk;

    noc_packet_receiver_if link();

    noc_packet_receiver #(
        .X_ID        (4'd1),
        .Y_ID        (4'd2),
        .MAX_PAYLOAD (2)
    ) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .link      (link),
        .pkt_done  (pkt_done),
        .pkt_src_x (pkt_src_x),
        .pkt_src_y (pkt_src_y),
        .pkt_len   (pkt_len),
        .err_valid (err_valid),
        .err_code  (err_code),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    typedef struct packed {logic [31:0] data; logic last;} beat_t;
    typedef struct packed {logic [3:0] x; logic [3:0] y; logic [7:0] len;} done_t;

    beat_t      beat_q[$];
    done_t      done_q[$];
    logic [2:0] err_q[$];
    int         checks = 0;
    int         errors = 0;

    localparam logic [31:0] c_tail     = {4'hC, 16'h0000, 4'h3, 8'h00};
    localparam logic [31:0] c_bad_tail = {4'hC, 16'h0000, 4'h7, 8'h00};

    function automatic logic [31:0] hdr(input logic [3:0] sx, sy, dx, dy);
        return {4'hA, sx, sy, dx, dy, 4'h5, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] f, input logic h, input logic t);
        int n;
        @(negedge noc_clk);
        link.receive_valid     = 1'b1;
        link.receive_flit      = f;
        link.receive_is_header = h;
        link.receive_is_tail   = t;
        #1;
        n = 0;
        while (!link.receive_ready && n < 100) begin
            @(negedge noc_clk);
            #1;
            n++;
        end
        check("send_timeout", 64'(n < 100), 64'd1);
        @(posedge noc_clk);
        #1;
        link.receive_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((beat_q.size() + done_q.size() + err_q.size()) != 0 && n < 200) begin
            @(negedge noc_clk);
            n++;
        end
        repeat (2) @(negedge noc_clk);
        check("drain_pending", 64'(beat_q.size() + done_q.size() + err_q.size()), 64'd0);
    endtask

    // Output monitors: scoreboard pops plus stall-stability check.
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    always @(negedge noc_clk) begin
        beat_t b;
        b = {link.payload_data, link.payload_last};
        if (!noc_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (link.payload_valid && stall_prev)
                check("stall_stable", 64'(b), 64'(stall_beat));
            stall_prev = link.payload_valid && !link.payload_ready;
            stall_beat = b;
            if (link.payload_valid && link.payload_ready) begin
                check("beat_expected", 64'(beat_q.size() != 0), 64'd1);
                if (beat_q.size() != 0) check("beat", 64'(b), 64'(beat_q.pop_front()));
            end
            if (pkt_done) begin
                check("done_expected", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0)
                    check("done_info", 64'({pkt_src_x, pkt_src_y, pkt_len}), 64'(done_q.pop_front()));
            end
            if (err_valid) begin
                check("err_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) check("err_code", 64'(err_code), 64'(err_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        link.receive_valid     = 1'b0;
        link.receive_flit      = '0;
        link.receive_is_header = 1'b0;
        link.receive_is_tail   = 1'b0;
        link.payload_ready     = 1'b1;

        // Reset state
        repeat (3) @(negedge noc_clk);
        check("rst_payload_valid", 64'(link.payload_valid), 64'd0);
        check("rst_flags", 64'({pkt_done, err_valid}), 64'd0);
        check("rst_counts", 64'({pkt_count, err_count}), 64'd0);
        check("rst_status", 64'({pkt_src_x, pkt_src_y, pkt_len, err_code}), 64'd0);
        check("rst_ready", 64'(link.receive_ready), 64'd1);
        noc_rst_n = 1'b1;

        // 1: basic two-flit packet
        beat_q.push_back({32'hD000_0000, 1'b0});
        beat_q.push_back({32'hD000_0001, 1'b1});
        done_q.push_back({4'd0, 4'd0, 8'd2});
        send(hdr(4'd0, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_0000, 1'b0, 1'b0);
        send(32'hD000_0001, 1'b0, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        drain();
        check("t1_pkt_count", 64'(pkt_count), 64'd1);

        // 2: consumer stall with back-pressure
        beat_q.push_back({32'hD000_0002, 1'b0});
        beat_q.push_back({32'hD000_0003, 1'b1});
        done_q.push_back({4'd0, 4'd0, 8'd2});
        send(hdr(4'd0, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_0002, 1'b0, 1'b0);
        link.payload_ready = 1'b0;
        send(32'hD000_0003, 1'b0, 1'b0);
        @(negedge noc_clk);
        check("t2_ready_low", 64'(link.receive_ready), 64'd0);
        fork
            send(c_tail, 1'b0, 1'b1);
            begin
                repeat (5) @(posedge noc_clk);
                #1 link.payload_ready = 1'b1;
            end
        join
        drain();
        check("t2_pkt_count", 64'(pkt_count), 64'd2);

        // 3: empty packet
        done_q.push_back({4'd3, 4'd1, 8'd0});
        send(hdr(4'd3, 4'd1, 4'd1, 4'd2), 1'b1, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        drain();
        check("t3_pkt_count", 64'(pkt_count), 64'd3);

        // 4: orphan data flit
        err_q.push_back(3'd1);
        send(32'hDEAD_0004, 1'b0, 1'b0);
        drain();
        check("t4_err_count", 64'(err_count), 64'd1);

        // 5: wrong destination, then a good packet
        err_q.push_back(3'd2);
        send(hdr(4'd0, 4'd0, 4'd3, 4'd3), 1'b1, 1'b0);
        send(32'hDEAD_0005, 1'b0, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        beat_q.push_back({32'hD000_0005, 1'b1});
        done_q.push_back({4'd2, 4'd0, 8'd1});
        send(hdr(4'd2, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_0005, 1'b0, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        drain();
        check("t5_counts", 64'({pkt_count, err_count}), 64'({16'd4, 16'd2}));

        // 6: overlength packet with MAX_PAYLOAD=2
        beat_q.push_back({32'hD000_0006, 1'b0});
        err_q.push_back(3'd4);
        send(hdr(4'd0, 4'd1, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_0006, 1'b0, 1'b0);
        send(32'hD000_0007, 1'b0, 1'b0);
        send(32'hD000_0008, 1'b0, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        drain();
        check("t6_counts", 64'({pkt_count, err_count}), 64'({16'd4, 16'd3}));

        // Reset in the middle of a packet
        send(hdr(4'd1, 4'd1, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_0009, 1'b0, 1'b0);
        @(negedge noc_clk);
        noc_rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 64'({link.payload_valid, pkt_done, err_valid}), 64'd0);
        check("mid_rst_counts", 64'({pkt_count, err_count}), 64'd0);
        check("mid_rst_ready", 64'(link.receive_ready), 64'd1);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        beat_q.push_back({32'hD000_000A, 1'b1});
        done_q.push_back({4'd0, 4'd0, 8'd1});
        send(hdr(4'd0, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_000A, 1'b0, 1'b0);
        send(c_tail, 1'b0, 1'b1);
        drain();
        check("post_rst_counts", 64'({pkt_count, err_count}), 64'({16'd1, 16'd0}));

        // Bad tail marker: packet still closes, err 5 alongside pkt_done
        beat_q.push_back({32'hD000_000B, 1'b1});
        done_q.push_back({4'd5, 4'd6, 8'd1});
        err_q.push_back(3'd5);
        send(hdr(4'd5, 4'd6, 4'd1, 4'd2), 1'b1, 1'b0);
        send(32'hD000_000B, 1'b0, 1'b0);
        send(c_bad_tail, 1'b0, 1'b1);
        drain();
        check("bad_tail_counts", 64'({pkt_count, err_count}), 64'({16'd2, 16'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
